esteira_vinho_param: RTL and testbench

Parametrised wine-bottling conveyor sequencer: one FSM drives the belt, fill valve, sealing actuator and QC/discard path. It also owns a configurable cork magazine with automatic refill, a bottles-per-box counter, a box counter and a reject counter. It sits between the debounced key/switch layer and the BCD/7-segment display layer and outputs binary counts only. It replaces the fixed-size process/motor FSM pair plus the fixed cork and dozen counters.

---
 rtl/esteira_pkg.sv | 21 ++
 rtl/esteira_vinho_param_if.sv | 36 +++
 rtl/magazine_rolhas.sv | 46 ++++
 rtl/esteira_vinho_param.sv | 174 +++++++++++++++++
 tb/tb_esteira_vinho_param.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/esteira_pkg.sv
// Shared types and widths for the wine-bottling conveyor sequencer.
package esteira_pkg;

  localparam int unsigned ESTADO_W     = 4;
  localparam int unsigned DESCARTE_W   = 8;
  localparam int unsigned DESCARTE_MAX = (1 << DESCARTE_W) - 1;

  typedef enum logic [ESTADO_W-1:0] {
    IDLE       = 4'd0,
    MOVE_FILL  = 4'd1,
    FILL       = 4'd2,
    SEAL       = 4'd3,
    ALARM      = 4'd4,
    MOVE_CQ    = 4'd5,
    CQ         = 4'd6,
    MOVE_LACRE = 4'd7,
    LACRE      = 4'd8,
    FAULT      = 4'd9
  } estado_t;

endpackage

// File: rtl/esteira_vinho_param_if.sv
// Key/sensor inputs and actuator/count outputs of the conveyor sequencer.
interface esteira_vinho_param_if #(
  parameter int unsigned ROLHA_MAX      = 20,
  parameter int unsigned GARRAFAS_CAIXA = 12,
  parameter int unsigned CAIXA_MAX      = 99
);
  logic KEY_START, KEY_VEDAR, KEY_ENTER_CQ, KEY_LACRE_CONTA, SW_ADD_ROLHA;
  logic SW_QUALIDADE_OK;
  logic SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA;
  logic LED_MOTOR, VALVULA_ENCHIMENTO, LED_ALARME_ROLHA;
  logic ATUADOR_VEDACAO, LED_DESCARTE, DISPENSADOR_ROLHAS;
  logic LED_FALHA;
  logic [$clog2(ROLHA_MAX + 1)-1:0] CONT_ROLHAS;
  logic [$clog2(GARRAFAS_CAIXA)-1:0] CONT_GARRAFAS;
  logic [$clog2(CAIXA_MAX + 1)-1:0]  CONT_CAIXAS;
  logic [7:0] CONT_DESCARTE;
  logic [3:0] Estado_Atual;

  modport master (
    output KEY_START, KEY_VEDAR, KEY_ENTER_CQ, KEY_LACRE_CONTA, SW_ADD_ROLHA,
    output SW_QUALIDADE_OK,
    output SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA,
    input  LED_MOTOR, VALVULA_ENCHIMENTO, LED_ALARME_ROLHA,
    input  ATUADOR_VEDACAO, LED_DESCARTE, DISPENSADOR_ROLHAS, LED_FALHA,
    input  CONT_ROLHAS, CONT_GARRAFAS, CONT_CAIXAS, CONT_DESCARTE, Estado_Atual
  );

  modport slave (
    input  KEY_START, KEY_VEDAR, KEY_ENTER_CQ, KEY_LACRE_CONTA, SW_ADD_ROLHA,
    input  SW_QUALIDADE_OK,
    input  SENSOR_POS_ENCHIMENTO, SENSOR_POS_CQ, SENSOR_POS_LACRE, SENSOR_GARRAFA_CHEIA,
    output LED_MOTOR, VALVULA_ENCHIMENTO, LED_ALARME_ROLHA,
    output ATUADOR_VEDACAO, LED_DESCARTE, DISPENSADOR_ROLHAS, LED_FALHA,
    output CONT_ROLHAS, CONT_GARRAFAS, CONT_CAIXAS, CONT_DESCARTE, Estado_Atual
  );
endinterface

// File: rtl/magazine_rolhas.sv
// Cork magazine: saturating count with manual add, seal decrement and auto refill.
module magazine_rolhas #(
  parameter int unsigned ROLHA_MAX    = 20,
  parameter int unsigned ROLHA_INIT   = 15,
  parameter int unsigned ROLHA_MIN    = 5,
  parameter int unsigned ROLHA_REFILL = 15,
  localparam int unsigned RW = $clog2(ROLHA_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          add_manual,
  output logic [RW-1:0] count,
  output logic          rolha_disponivel,
  output logic          dispensador
);

  logic [RW-1:0] count_q, count_d;
  logic          disp_q, disp_d;
  int unsigned   soma;

  // Net of add, refill and decrement, saturated once at the top
  always_comb begin
    disp_d = (32'(count_q) <= ROLHA_MIN) && !disp_q;
    soma   = 32'(count_q);
    if (add_manual) soma = soma + 32'd1;
    if (disp_d)     soma = soma + ROLHA_REFILL;
    if (dec && soma != 32'd0) soma = soma - 32'd1;
    count_d = (soma > ROLHA_MAX) ? RW'(ROLHA_MAX) : RW'(soma);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RW'(ROLHA_INIT);
      disp_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      disp_q  <= disp_d;
    end
  end

  assign count            = count_q;
  assign rolha_disponivel = (count_q != '0);
  assign dispensador      = disp_q;

endmodule

// File: rtl/esteira_vinho_param.sv
// Conveyor sequencer FSM with bottle/box/reject counters and cork magazine.
// Optional watchdog fault state enabled by ESTEIRA_WATCHDOG_EN.
module esteira_vinho_param
  import esteira_pkg::*;
#(
  parameter int unsigned ROLHA_MAX      = 20,
  parameter int unsigned ROLHA_INIT     = 15,
  parameter int unsigned ROLHA_MIN      = 5,
  parameter int unsigned ROLHA_REFILL   = 15,
  parameter int unsigned GARRAFAS_CAIXA = 12,
  parameter int unsigned CAIXA_MAX      = 99,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                  CLK,
  input logic                  RESET,
  esteira_vinho_param_if.slave bus
);

  localparam int unsigned RW = $clog2(ROLHA_MAX + 1);
  localparam int unsigned GW = $clog2(GARRAFAS_CAIXA);
  localparam int unsigned CW = $clog2(CAIXA_MAX + 1);

  if (ROLHA_INIT > ROLHA_MAX || TIMEOUT_CYCLES == 0) begin : g_param_err
    $error("esteira_vinho_param: invalid parameter set");
  end

  estado_t               state_q, state_d;
  logic [GW-1:0]         garrafas_q, garrafas_d;
  logic [CW-1:0]         caixas_q, caixas_d;
  logic [DESCARTE_W-1:0] descarte_q, descarte_d;
  logic                  atuador_q, atuador_d, descarte_led_q, descarte_led_d;
  logic                  motor_q, motor_d, valvula_q, valvula_d, alarme_q, alarme_d;
  logic                  dec_c, rolha_disponivel, dispensador;
  logic [RW-1:0]         rolhas;

`ifdef ESTEIRA_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           falha_q, falha_d;
`endif

  magazine_rolhas #(
    .ROLHA_MAX   (ROLHA_MAX),
    .ROLHA_INIT  (ROLHA_INIT),
    .ROLHA_MIN   (ROLHA_MIN),
    .ROLHA_REFILL(ROLHA_REFILL)
  ) u_magazine (
    .clk             (CLK),
    .rst_n           (RESET),
    .dec             (dec_c),
    .add_manual      (bus.SW_ADD_ROLHA),
    .count           (rolhas),
    .rolha_disponivel(rolha_disponivel),
    .dispensador     (dispensador)
  );

  always_comb begin
    state_d        = state_q;
    garrafas_d     = garrafas_q;
    caixas_d       = caixas_q;
    descarte_d     = descarte_q;
    atuador_d      = 1'b0;
    descarte_led_d = 1'b0;
    dec_c          = 1'b0;
    case (state_q)
      IDLE:       if (bus.KEY_START) state_d = MOVE_FILL;
      MOVE_FILL:  if (bus.SENSOR_POS_ENCHIMENTO) state_d = FILL;
      FILL:       if (bus.SENSOR_GARRAFA_CHEIA) state_d = SEAL;
      SEAL: begin
        if (!rolha_disponivel) begin
          state_d = ALARM;
        end else if (bus.KEY_VEDAR) begin
          atuador_d = 1'b1;
          dec_c     = 1'b1;
          state_d   = MOVE_CQ;
        end
      end
      ALARM:      if (rolha_disponivel) state_d = SEAL;
      MOVE_CQ:    if (bus.SENSOR_POS_CQ) state_d = CQ;
      CQ: begin
        if (bus.KEY_ENTER_CQ) begin
          if (bus.SW_QUALIDADE_OK) begin
            state_d = MOVE_LACRE;
          end else begin
            descarte_led_d = 1'b1;
            if (descarte_q != DESCARTE_W'(DESCARTE_MAX)) descarte_d = descarte_q + DESCARTE_W'(1);
            state_d = MOVE_FILL;
          end
        end
      end
      MOVE_LACRE: if (bus.SENSOR_POS_LACRE) state_d = LACRE;
      LACRE: begin
        if (bus.KEY_LACRE_CONTA) begin
          // Last bottle of a box closes it and starts the next one
          if (garrafas_q == GW'(GARRAFAS_CAIXA - 1)) begin
            garrafas_d = '0;
            caixas_d   = (caixas_q == CW'(CAIXA_MAX)) ? '0 : caixas_q + CW'(1);
          end else begin
            garrafas_d = garrafas_q + GW'(1);
          end
          state_d = MOVE_FILL;
        end
      end
      FAULT:      state_d = FAULT;
      default:    state_d = IDLE;
    endcase

`ifdef ESTEIRA_WATCHDOG_EN
    // Timeout only fires while the bottle is stuck in a timed state
    wd_d = '0;
    if (state_d == state_q && (state_q inside {MOVE_FILL, FILL, MOVE_CQ, MOVE_LACRE})) begin
      if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) state_d = FAULT;
      else                                  wd_d = wd_q + WDW'(1);
    end
    falha_d = (state_d == FAULT);
`endif

    motor_d   = state_d inside {MOVE_FILL, MOVE_CQ, MOVE_LACRE};
    valvula_d = (state_d == FILL);
    alarme_d  = (state_d == ALARM);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q        <= IDLE;
      garrafas_q     <= '0;
      caixas_q       <= '0;
      descarte_q     <= '0;
      atuador_q      <= 1'b0;
      descarte_led_q <= 1'b0;
      motor_q        <= 1'b0;
      valvula_q      <= 1'b0;
      alarme_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      garrafas_q     <= garrafas_d;
      caixas_q       <= caixas_d;
      descarte_q     <= descarte_d;
      atuador_q      <= atuador_d;
      descarte_led_q <= descarte_led_d;
      motor_q        <= motor_d;
      valvula_q      <= valvula_d;
      alarme_q       <= alarme_d;
    end
  end

`ifdef ESTEIRA_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wd_q    <= '0;
      falha_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      falha_q <= falha_d;
    end
  end
  assign bus.LED_FALHA = falha_q;
`else
  assign bus.LED_FALHA = 1'b0;
`endif

  assign bus.LED_MOTOR          = motor_q;
  assign bus.VALVULA_ENCHIMENTO = valvula_q;
  assign bus.LED_ALARME_ROLHA   = alarme_q;
  assign bus.ATUADOR_VEDACAO    = atuador_q;
  assign bus.LED_DESCARTE       = descarte_led_q;
  assign bus.DISPENSADOR_ROLHAS = dispensador;
  assign bus.CONT_ROLHAS        = rolhas;
  assign bus.CONT_GARRAFAS      = garrafas_q;
  assign bus.CONT_CAIXAS        = caixas_q;
  assign bus.CONT_DESCARTE      = descarte_q;
  assign bus.Estado_Atual       = state_q;

endmodule

// File: tb/tb_esteira_vinho_param.sv
// Directed bench: default line (a), empty magazine with 2-bottle boxes (b), refill-from-zero (c).
module tb_esteira_vinho_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  esteira_vinho_param_if #(.ROLHA_MAX(20), .GARRAFAS_CAIXA(12), .CAIXA_MAX(99)) ia ();
  esteira_vinho_param_if #(.ROLHA_MAX(20), .GARRAFAS_CAIXA(2),  .CAIXA_MAX(1))  ib ();
  esteira_vinho_param_if #(.ROLHA_MAX(20), .GARRAFAS_CAIXA(12), .CAIXA_MAX(99)) ic ();

  esteira_vinho_param dut_a (.CLK(clk), .RESET(rst_n), .bus(ia.slave));

  esteira_vinho_param #(
    .ROLHA_INIT(0), .ROLHA_REFILL(0), .GARRAFAS_CAIXA(2), .CAIXA_MAX(1), .TIMEOUT_CYCLES(50)
  ) dut_b (.CLK(clk), .RESET(rst_n), .bus(ib.slave));

  esteira_vinho_param #(.ROLHA_INIT(0)) dut_c (.CLK(clk), .RESET(rst_n), .bus(ic.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // dut_a: from MOVE_FILL through seal to CQ
  task automatic a_to_cq(input bit add_with_vedar);
    ia.SENSOR_POS_ENCHIMENTO = 1'b1; tick(); ia.SENSOR_POS_ENCHIMENTO = 1'b0;
    ia.SENSOR_GARRAFA_CHEIA  = 1'b1; tick(); ia.SENSOR_GARRAFA_CHEIA  = 1'b0;
    ia.KEY_VEDAR = 1'b1; ia.SW_ADD_ROLHA = add_with_vedar; tick();
    ia.KEY_VEDAR = 1'b0; ia.SW_ADD_ROLHA = 1'b0;
    ia.SENSOR_POS_CQ = 1'b1; tick(); ia.SENSOR_POS_CQ = 1'b0;
  endtask

  task automatic a_finish_good();
    ia.SW_QUALIDADE_OK = 1'b1; ia.KEY_ENTER_CQ = 1'b1; tick(); ia.KEY_ENTER_CQ = 1'b0;
    ia.SENSOR_POS_LACRE = 1'b1; tick(); ia.SENSOR_POS_LACRE = 1'b0;
    ia.KEY_LACRE_CONTA = 1'b1; tick(); ia.KEY_LACRE_CONTA = 1'b0;
  endtask

  // dut_b: one good bottle, passing through ALARM and a manual cork add
  task automatic b_bottle();
    ib.SENSOR_POS_ENCHIMENTO = 1'b1; tick(); ib.SENSOR_POS_ENCHIMENTO = 1'b0;
    ib.SENSOR_GARRAFA_CHEIA  = 1'b1; tick(); ib.SENSOR_GARRAFA_CHEIA  = 1'b0;
    tick();
    ib.SW_ADD_ROLHA = 1'b1; tick(); ib.SW_ADD_ROLHA = 1'b0;
    tick();
    ib.KEY_VEDAR = 1'b1; tick(); ib.KEY_VEDAR = 1'b0;
    ib.SENSOR_POS_CQ = 1'b1; tick(); ib.SENSOR_POS_CQ = 1'b0;
    ib.SW_QUALIDADE_OK = 1'b1; ib.KEY_ENTER_CQ = 1'b1; tick(); ib.KEY_ENTER_CQ = 1'b0;
    ib.SENSOR_POS_LACRE = 1'b1; tick(); ib.SENSOR_POS_LACRE = 1'b0;
    ib.KEY_LACRE_CONTA = 1'b1; tick(); ib.KEY_LACRE_CONTA = 1'b0;
  endtask

  initial begin
    {ia.KEY_START, ia.KEY_VEDAR, ia.KEY_ENTER_CQ, ia.KEY_LACRE_CONTA, ia.SW_ADD_ROLHA,
     ia.SW_QUALIDADE_OK, ia.SENSOR_POS_ENCHIMENTO, ia.SENSOR_POS_CQ, ia.SENSOR_POS_LACRE,
     ia.SENSOR_GARRAFA_CHEIA} = '0;
    {ib.KEY_START, ib.KEY_VEDAR, ib.KEY_ENTER_CQ, ib.KEY_LACRE_CONTA, ib.SW_ADD_ROLHA,
     ib.SW_QUALIDADE_OK, ib.SENSOR_POS_ENCHIMENTO, ib.SENSOR_POS_CQ, ib.SENSOR_POS_LACRE,
     ib.SENSOR_GARRAFA_CHEIA} = '0;
    {ic.KEY_START, ic.KEY_VEDAR, ic.KEY_ENTER_CQ, ic.KEY_LACRE_CONTA, ic.SW_ADD_ROLHA,
     ic.SW_QUALIDADE_OK, ic.SENSOR_POS_ENCHIMENTO, ic.SENSOR_POS_CQ, ic.SENSOR_POS_LACRE,
     ic.SENSOR_GARRAFA_CHEIA} = '0;

    // Reset state
    tick(); tick(); tick();
    chk("a_rst_state",    ia.Estado_Atual, 0);
    chk("a_rst_rolhas",   ia.CONT_ROLHAS, 15);
    chk("a_rst_garrafas", ia.CONT_GARRAFAS, 0);
    chk("a_rst_caixas",   ia.CONT_CAIXAS, 0);
    chk("a_rst_descarte", ia.CONT_DESCARTE, 0);
    chk("a_rst_motor",    ia.LED_MOTOR, 0);
    chk("a_rst_falha",    ia.LED_FALHA, 0);
    chk("c_rst_rolhas",   ic.CONT_ROLHAS, 0);
    chk("c_rst_disp",     ic.DISPENSADOR_ROLHAS, 0);

    // Auto refill from an empty magazine on the first active edge
    rst_n = 1'b1;
    tick();
    chk("c_refill_disp",   ic.DISPENSADOR_ROLHAS, 1);
    chk("c_refill_rolhas", ic.CONT_ROLHAS, 15);
    chk("a_no_refill",     ia.DISPENSADOR_ROLHAS, 0);
    tick();
    chk("c_disp_one_cycle", ic.DISPENSADOR_ROLHAS, 0);
    chk("c_rolhas_hold",    ic.CONT_ROLHAS, 15);

    // Full good bottle on dut_a, station by station
    ia.KEY_START = 1'b1; tick(); ia.KEY_START = 1'b0;
    chk("a_move_fill", ia.Estado_Atual, 1);
    chk("a_motor_mf",  ia.LED_MOTOR, 1);
    ia.SENSOR_POS_ENCHIMENTO = 1'b1; tick(); ia.SENSOR_POS_ENCHIMENTO = 1'b0;
    chk("a_fill",       ia.Estado_Atual, 2);
    chk("a_motor_fill", ia.LED_MOTOR, 0);
    chk("a_valve_fill", ia.VALVULA_ENCHIMENTO, 1);
    ia.SENSOR_GARRAFA_CHEIA = 1'b1; tick(); ia.SENSOR_GARRAFA_CHEIA = 1'b0;
    chk("a_seal",       ia.Estado_Atual, 3);
    chk("a_valve_seal", ia.VALVULA_ENCHIMENTO, 0);
    chk("a_motor_seal", ia.LED_MOTOR, 0);
    ia.KEY_VEDAR = 1'b1; tick(); ia.KEY_VEDAR = 1'b0;
    chk("a_move_cq",     ia.Estado_Atual, 5);
    chk("a_atuador_on",  ia.ATUADOR_VEDACAO, 1);
    chk("a_rolhas_dec",  ia.CONT_ROLHAS, 14);
    ia.SENSOR_POS_CQ = 1'b1; tick(); ia.SENSOR_POS_CQ = 1'b0;
    chk("a_atuador_off", ia.ATUADOR_VEDACAO, 0);
    chk("a_cq",          ia.Estado_Atual, 6);
    chk("a_motor_cq",    ia.LED_MOTOR, 0);
    ia.SW_QUALIDADE_OK = 1'b1; ia.KEY_ENTER_CQ = 1'b1; tick(); ia.KEY_ENTER_CQ = 1'b0;
    chk("a_move_lacre",  ia.Estado_Atual, 7);
    chk("a_no_descarte", ia.LED_DESCARTE, 0);
    ia.SENSOR_POS_LACRE = 1'b1; tick(); ia.SENSOR_POS_LACRE = 1'b0;
    chk("a_lacre",       ia.Estado_Atual, 8);
    chk("a_motor_lacre", ia.LED_MOTOR, 0);
    ia.KEY_LACRE_CONTA = 1'b1; tick(); ia.KEY_LACRE_CONTA = 1'b0;
    chk("a_back_mf",  ia.Estado_Atual, 1);
    chk("a_garr_1",   ia.CONT_GARRAFAS, 1);
    chk("a_rolhas_14", ia.CONT_ROLHAS, 14);

    // Bottles 2..5 bring the magazine to 10
    for (int i = 0; i < 4; i++) begin
      a_to_cq(1'b0);
      a_finish_good();
    end
    chk("a_rolhas_10", ia.CONT_ROLHAS, 10);
    chk("a_garr_5",    ia.CONT_GARRAFAS, 5);

    // Seal coinciding with a manual add nets to zero
    a_to_cq(1'b1);
    chk("a_vedar_add_net", ia.CONT_ROLHAS, 10);
    a_finish_good();
    chk("a_garr_6", ia.CONT_GARRAFAS, 6);

    // QC reject
    a_to_cq(1'b0);
    ia.SW_QUALIDADE_OK = 1'b0; ia.KEY_ENTER_CQ = 1'b1; tick(); ia.KEY_ENTER_CQ = 1'b0;
    chk("a_descarte_pulse", ia.LED_DESCARTE, 1);
    chk("a_descarte_cnt",   ia.CONT_DESCARTE, 1);
    chk("a_reject_state",   ia.Estado_Atual, 1);
    chk("a_reject_garr",    ia.CONT_GARRAFAS, 6);
    chk("a_reject_rolhas",  ia.CONT_ROLHAS, 9);
    tick();
    chk("a_descarte_off", ia.LED_DESCARTE, 0);

    // Bottles 7..12: 9 -> 5 triggers a refill to 20, then 19, 18; box closes
    for (int i = 0; i < 6; i++) begin
      a_to_cq(1'b0);
      a_finish_good();
    end
    chk("a_box_garr",   ia.CONT_GARRAFAS, 0);
    chk("a_box_caixas", ia.CONT_CAIXAS, 1);
    chk("a_rolhas_18",  ia.CONT_ROLHAS, 18);

    // Manual add saturates at ROLHA_MAX
    for (int i = 0; i < 3; i++) begin
      ia.SW_ADD_ROLHA = 1'b1; tick(); ia.SW_ADD_ROLHA = 1'b0;
    end
    chk("a_rolhas_sat", ia.CONT_ROLHAS, 20);
    ia.KEY_START = 1'b1; tick(); ia.KEY_START = 1'b0;
    chk("a_start_ignored", ia.Estado_Atual, 1);

    // dut_b: empty magazine forces ALARM until a cork is added
    ib.KEY_START = 1'b1; tick(); ib.KEY_START = 1'b0;
    ib.SENSOR_POS_ENCHIMENTO = 1'b1; tick(); ib.SENSOR_POS_ENCHIMENTO = 1'b0;
    ib.SENSOR_GARRAFA_CHEIA  = 1'b1; tick(); ib.SENSOR_GARRAFA_CHEIA  = 1'b0;
    chk("b_seal", ib.Estado_Atual, 3);
    tick();
    chk("b_alarm",     ib.Estado_Atual, 4);
    chk("b_alarm_led", ib.LED_ALARME_ROLHA, 1);
    ib.SW_ADD_ROLHA = 1'b1; tick(); ib.SW_ADD_ROLHA = 1'b0;
    chk("b_add_rolhas", ib.CONT_ROLHAS, 1);
    chk("b_still_alarm", ib.Estado_Atual, 4);
    tick();
    chk("b_back_seal",  ib.Estado_Atual, 3);
    chk("b_alarm_off",  ib.LED_ALARME_ROLHA, 0);
    ib.KEY_VEDAR = 1'b1; tick(); ib.KEY_VEDAR = 1'b0;
    chk("b_rolhas_0", ib.CONT_ROLHAS, 0);
    ib.SENSOR_POS_CQ = 1'b1; tick(); ib.SENSOR_POS_CQ = 1'b0;
    ib.SW_QUALIDADE_OK = 1'b1; ib.KEY_ENTER_CQ = 1'b1; tick(); ib.KEY_ENTER_CQ = 1'b0;
    ib.SENSOR_POS_LACRE = 1'b1; tick(); ib.SENSOR_POS_LACRE = 1'b0;
    ib.KEY_LACRE_CONTA = 1'b1; tick(); ib.KEY_LACRE_CONTA = 1'b0;
    chk("b_garr_1", ib.CONT_GARRAFAS, 1);

    // Two-bottle boxes, box counter wraps at CAIXA_MAX=1
    b_bottle();
    chk("b_box1_garr",   ib.CONT_GARRAFAS, 0);
    chk("b_box1_caixas", ib.CONT_CAIXAS, 1);
    b_bottle();
    b_bottle();
    chk("b_wrap_caixas", ib.CONT_CAIXAS, 0);
    chk("b_wrap_garr",   ib.CONT_GARRAFAS, 0);
    chk("b_wrap_state",  ib.Estado_Atual, 1);

`ifdef ESTEIRA_WATCHDOG_EN
    // No sensor in MOVE_FILL: FAULT on the 50th cycle
    for (int i = 0; i < 49; i++) tick();
    chk("b_wd_before",   ib.Estado_Atual, 1);
    chk("b_wd_motor_on", ib.LED_MOTOR, 1);
    tick();
    chk("b_wd_fault",    ib.Estado_Atual, 9);
    chk("b_wd_motor",    ib.LED_MOTOR, 0);
    chk("b_wd_falha",    ib.LED_FALHA, 1);
    ib.SENSOR_POS_ENCHIMENTO = 1'b1; ib.KEY_START = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ib.SENSOR_POS_ENCHIMENTO = 1'b0; ib.KEY_START = 1'b0;
    chk("b_wd_sticky",   ib.Estado_Atual, 9);
    chk("b_wd_falha_hold", ib.LED_FALHA, 1);
`else
    for (int i = 0; i < 60; i++) tick();
    chk("b_no_wd_state", ib.Estado_Atual, 1);
    chk("b_no_wd_falha", ib.LED_FALHA, 0);
`endif

    // Reset clears everything
    rst_n = 1'b0; tick();
    chk("b_rst_state",  ib.Estado_Atual, 0);
    chk("b_rst_falha",  ib.LED_FALHA, 0);
    chk("b_rst_motor",  ib.LED_MOTOR, 0);
    chk("b_rst_rolhas", ib.CONT_ROLHAS, 0);
    chk("a_rst2_rolhas", ia.CONT_ROLHAS, 15);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
